// File: rtl/seq_table_gen.sv
// Table-driven output sequencer: steps through 3-word lines held in block RAM,
// each with a repeat count, an optional bit trigger and two timed output phases.
module seq_table_gen #(
   parameter int DEPTH = 512,
   parameter int NOUT  = 6,
   parameter int NBIT  = 3
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            enable_i,
   input  logic [NBIT-1:0] bit_i,
   output logic [NOUT-1:0] out_o,
   output logic            active_o,
   input  logic [31:0]     PRESCALE,
   input  logic            TABLE_START,
   input  logic [31:0]     TABLE_DATA,
   input  logic            TABLE_WSTB,
   input  logic [15:0]     TABLE_LENGTH,
   input  logic            TABLE_LENGTH_WSTB,
   input  logic [31:0]     REPEATS,
   output logic [31:0]     table_line_o,
   output logic [31:0]     line_repeat_o,
   output logic [31:0]     table_repeat_o,
   output logic [2:0]      state_o,
   output logic            health_o
);
   localparam int NWORDS = 3 * DEPTH;
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW     = $clog2(NWORDS + 1);

   typedef enum logic [2:0] {
      UNREADY = 3'd0, WAIT_ENABLE = 3'd1, LOAD = 3'd2,
      WAIT_TRIG = 3'd3, PHASE1 = 3'd4, PHASE2 = 3'd5
   } state_t;

   typedef struct packed {
      logic [15:0]     reps;
      logic [1:0]      mode;
      logic [3:0]      idx;
      logic [NOUT-1:0] p1;
      logic [NOUT-1:0] p2;
      logic [15:0]     t1;
      logic [15:0]     t2;
   } line_t;

   state_t          state_q, state_d;
   logic [NOUT-1:0] out_q, out_d;
   logic            active_q, active_d, health_q, health_d;
   logic [31:0]     table_line_q, table_line_d, line_rep_q, line_rep_d;
   logic [31:0]     table_rep_q, table_rep_d, nlines_q, nlines_d;
   logic [31:0]     presc_q, presc_d;
   logic [15:0]     tcnt_q, tcnt_d;
   logic            load_q, load_d, en_prev_q, en_prev_d;
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [AW-1:0]   wline_q, wline_d, rd_addr;
   logic [1:0]      wsel_q, wsel_d;
   line_t           lw_q, lw_d, rd_q;
   logic            wr_en, active_st, len_ok, bit_sel, trig_ok, tick, phase_done, end_rep;
   logic [31:0]     p_eff;
   logic [15:0]     t_cur;

   // Each line is split across three word banks so a whole line reads in one cycle.
   logic [31:0] mem0 [DEPTH];
   logic [31:0] mem1 [DEPTH];
   logic [31:0] mem2 [DEPTH];

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   assign rd_addr = AW'(table_line_q - 32'd1);

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         if (wsel_q == 2'd0)      mem0[wline_q] <= TABLE_DATA;
         else if (wsel_q == 2'd1) mem1[wline_q] <= TABLE_DATA;
         else                     mem2[wline_q] <= TABLE_DATA;
      end
      rd_q.reps <= mem0[rd_addr][15:0];
      rd_q.mode <= mem0[rd_addr][17:16];
      rd_q.idx  <= mem0[rd_addr][23:20];
      rd_q.p1   <= mem1[rd_addr][NOUT-1:0];
      rd_q.p2   <= mem1[rd_addr][16+NOUT-1:16];
      rd_q.t1   <= mem2[rd_addr][15:0];
      rd_q.t2   <= mem2[rd_addr][31:16];
   end

   always_comb begin
      bit_sel = 1'b0;
      for (int i = 0; i < NBIT; i++)
         if (lw_q.idx == 4'(i)) bit_sel = bit_i[i];
   end

   assign active_st = (state_q == LOAD) || (state_q == WAIT_TRIG) ||
                      (state_q == PHASE1) || (state_q == PHASE2);
   assign len_ok  = (TABLE_LENGTH != 16'd0) && ((TABLE_LENGTH % 16'd3) == 16'd0) &&
                    (32'(TABLE_LENGTH) <= 32'(NWORDS));
   // Out-of-range bit index and mode 3 both fall back to an immediate trigger.
   assign trig_ok = (32'(lw_q.idx) >= 32'(NBIT)) ? 1'b1 :
                    (lw_q.mode == 2'd1) ? bit_sel :
                    (lw_q.mode == 2'd2) ? !bit_sel : 1'b1;
   assign p_eff   = (PRESCALE == 32'd0) ? 32'd1 : PRESCALE;
   assign tick    = (presc_q == p_eff - 32'd1);
   assign t_cur   = (state_q == PHASE1) ? ((lw_q.t1 == 16'd0) ? 16'd1 : lw_q.t1) : lw_q.t2;

   always_comb begin
      state_d = state_q;  out_d = out_q;  active_d = active_q;  health_d = health_q;
      table_line_d = table_line_q;  line_rep_d = line_rep_q;  table_rep_d = table_rep_q;
      nlines_d = nlines_q;  presc_d = presc_q;  tcnt_d = tcnt_q;  load_d = load_q;
      lw_d = lw_q;  en_prev_d = enable_i;
      wptr_d = wptr_q;  wline_d = wline_q;  wsel_d = wsel_q;  wr_en = 1'b0;
      phase_done = 1'b0;  end_rep = 1'b0;

      if (TABLE_START) begin
         state_d = UNREADY;
         if (active_st) begin
            out_d = '0;  active_d = 1'b0;
            table_line_d = '0;  line_rep_d = '0;  table_rep_d = '0;
         end
      end else if (active_st && !enable_i) begin
         state_d = WAIT_ENABLE;  out_d = '0;  active_d = 1'b0;
      end else if (TABLE_LENGTH_WSTB && !active_st) begin
         if (len_ok) begin
            state_d = WAIT_ENABLE;  health_d = 1'b0;
            nlines_d = 32'(TABLE_LENGTH / 16'd3);
         end else begin
            state_d = UNREADY;  health_d = 1'b1;
         end
      end else begin
         if (TABLE_LENGTH_WSTB) health_d = 1'b1;
         if (state_q == PHASE1 || state_q == PHASE2) begin
            if (tick) begin
               presc_d = '0;
               if (tcnt_q == t_cur - 16'd1) phase_done = 1'b1;
               else                         tcnt_d = tcnt_q + 16'd1;
            end else begin
               presc_d = presc_q + 32'd1;
            end
         end
         case (state_q)
            WAIT_ENABLE: if (enable_i && !en_prev_q) begin
               state_d = LOAD;  active_d = 1'b1;  load_d = 1'b0;
               table_line_d = 32'd1;  line_rep_d = 32'd1;  table_rep_d = 32'd1;
            end
            LOAD: if (load_q) begin
               lw_d = rd_q;  state_d = WAIT_TRIG;  load_d = 1'b0;
            end else begin
               load_d = 1'b1;
            end
            WAIT_TRIG: if (trig_ok) begin
               state_d = PHASE1;  out_d = lw_q.p1;  presc_d = '0;  tcnt_d = '0;
            end
            PHASE1: if (phase_done) begin
               if (lw_q.t2 != 16'd0) begin
                  state_d = PHASE2;  out_d = lw_q.p2;  presc_d = '0;  tcnt_d = '0;
               end else begin
                  end_rep = 1'b1;
               end
            end
            PHASE2: if (phase_done) end_rep = 1'b1;
            default: ;
         endcase
         if (end_rep) begin
            if (lw_q.reps != 16'd0 && line_rep_q == 32'(lw_q.reps)) begin
               if (table_line_q >= nlines_q) begin
                  if (REPEATS != 32'd0 && table_rep_q == REPEATS) begin
                     state_d = WAIT_ENABLE;  out_d = '0;  active_d = 1'b0;
                  end else begin
                     table_rep_d = sat_inc(table_rep_q);  table_line_d = 32'd1;
                     line_rep_d = 32'd1;  state_d = LOAD;  load_d = 1'b0;
                  end
               end else begin
                  table_line_d = table_line_q + 32'd1;  line_rep_d = 32'd1;
                  state_d = LOAD;  load_d = 1'b0;
               end
            end else begin
               line_rep_d = sat_inc(line_rep_q);  state_d = WAIT_TRIG;
            end
         end
      end

      if (TABLE_START) begin
         wptr_d = '0;  wline_d = '0;  wsel_d = '0;
      end else if (TABLE_WSTB) begin
         if (wptr_q == PW'(NWORDS)) begin
            health_d = 1'b1;
         end else begin
            wr_en = 1'b1;  wptr_d = wptr_q + PW'(1);
            if (wsel_q == 2'd2) begin wsel_d = 2'd0;  wline_d = wline_q + AW'(1); end
            else                      wsel_d = wsel_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= UNREADY;  out_q <= '0;  active_q <= 1'b0;  health_q <= 1'b0;
         table_line_q <= '0;  line_rep_q <= '0;  table_rep_q <= '0;  nlines_q <= '0;
         presc_q <= '0;  tcnt_q <= '0;  load_q <= 1'b0;  en_prev_q <= 1'b0;
         wptr_q <= '0;  wline_q <= '0;  wsel_q <= '0;  lw_q <= '0;
      end else begin
         state_q <= state_d;  out_q <= out_d;  active_q <= active_d;  health_q <= health_d;
         table_line_q <= table_line_d;  line_rep_q <= line_rep_d;  table_rep_q <= table_rep_d;
         nlines_q <= nlines_d;  presc_q <= presc_d;  tcnt_q <= tcnt_d;  load_q <= load_d;
         en_prev_q <= en_prev_d;  wptr_q <= wptr_d;  wline_q <= wline_d;  wsel_q <= wsel_d;
         lw_q <= lw_d;
      end
   end

   assign out_o          = out_q;
   assign active_o       = active_q;
   assign health_o       = health_q;
   assign table_line_o   = table_line_q;
   assign line_repeat_o  = line_rep_q;
   assign table_repeat_o = table_rep_q;
   assign state_o        = state_q;
endmodule

// File: tb/tb_seq_table_gen.sv
// Directed bench for seq_table_gen: one task per scenario, inline checks at negedge.
module tb_seq_table_gen;
   localparam int DEPTH = 4;
   localparam int NOUT  = 6;
   localparam int NBIT  = 3;

   logic            clk = 1'b0;
   logic            reset_i = 1'b1, enable_i = 1'b0;
   logic [NBIT-1:0] bit_i = '0;
   logic [NOUT-1:0] out_o;
   logic            active_o, health_o;
   logic [31:0]     PRESCALE = 32'd1, TABLE_DATA = '0, REPEATS = 32'd1;
   logic            TABLE_START = 1'b0, TABLE_WSTB = 1'b0, TABLE_LENGTH_WSTB = 1'b0;
   logic [15:0]     TABLE_LENGTH = '0;
   logic [31:0]     table_line_o, line_repeat_o, table_repeat_o;
   logic [2:0]      state_o;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] tbl [6];

   seq_table_gen #(.DEPTH(DEPTH), .NOUT(NOUT), .NBIT(NBIT)) dut (
      .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .bit_i(bit_i),
      .out_o(out_o), .active_o(active_o), .PRESCALE(PRESCALE),
      .TABLE_START(TABLE_START), .TABLE_DATA(TABLE_DATA), .TABLE_WSTB(TABLE_WSTB),
      .TABLE_LENGTH(TABLE_LENGTH), .TABLE_LENGTH_WSTB(TABLE_LENGTH_WSTB),
      .REPEATS(REPEATS), .table_line_o(table_line_o), .line_repeat_o(line_repeat_o),
      .table_repeat_o(table_repeat_o), .state_o(state_o), .health_o(health_o)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] d);
      TABLE_DATA = d;  TABLE_WSTB = 1'b1;  step();  TABLE_WSTB = 1'b0;
   endtask

   task automatic commit(input logic [15:0] len);
      TABLE_LENGTH = len;  TABLE_LENGTH_WSTB = 1'b1;  step();  TABLE_LENGTH_WSTB = 1'b0;
   endtask

   task automatic program_tbl(input int n);
      TABLE_START = 1'b1;  step();  TABLE_START = 1'b0;
      for (int i = 0; i < n; i++) wr(tbl[i]);
      commit(16'(n));
   endtask

   // Leaves enable high just before the edge that sees the rising edge.
   task automatic start_run();
      enable_i = 1'b0;  step();  enable_i = 1'b1;
   endtask

   task automatic wait_st(input logic [2:0] s, input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (state_o === s) begin ok = 1'b1; break; end
         step();
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;  step(2);
      n_cmp++; if ({out_o, active_o, health_o, state_o} !== '0) begin n_bad++;
         $display("FAIL reset_outs out=%0d act=%0d hl=%0d st=%0d exp all 0", out_o, active_o, health_o, state_o); end
      n_cmp++; if ({table_line_o, line_repeat_o, table_repeat_o} !== '0) begin n_bad++;
         $display("FAIL reset_cnts line=%0d lrep=%0d trep=%0d exp 0", table_line_o, line_repeat_o, table_repeat_o); end
      reset_i = 1'b0;  step();
   endtask

   task automatic test_single_line();
      int eo [6] = '{1, 1, 2, 2, 2, 0};
      int es [6] = '{4, 4, 5, 5, 5, 1};
      PRESCALE = 32'd1;  REPEATS = 32'd1;
      tbl[0] = 32'h1;  tbl[1] = 32'h0002_0001;  tbl[2] = 32'h0003_0002;
      program_tbl(3);
      n_cmp++; if (state_o !== 3'd1 || health_o !== 1'b0) begin n_bad++;
         $display("FAIL t1_commit st=%0d hl=%0d exp 1/0", state_o, health_o); end
      start_run();  step();
      n_cmp++; if (state_o !== 3'd2 || active_o !== 1'b1) begin n_bad++;
         $display("FAIL t1_load st=%0d act=%0d exp 2/1", state_o, active_o); end
      n_cmp++; if (table_line_o !== 32'd1 || line_repeat_o !== 32'd1 || table_repeat_o !== 32'd1) begin n_bad++;
         $display("FAIL t1_cnt line=%0d lrep=%0d trep=%0d exp 1/1/1", table_line_o, line_repeat_o, table_repeat_o); end
      step();
      n_cmp++; if (state_o !== 3'd2) begin n_bad++; $display("FAIL t1_load2 st=%0d exp 2", state_o); end
      step();
      n_cmp++; if (state_o !== 3'd3 || out_o !== 6'd0) begin n_bad++;
         $display("FAIL t1_trig st=%0d out=%0d exp 3/0", state_o, out_o); end
      for (int i = 0; i < 6; i++) begin
         step();
         n_cmp++; if (out_o !== 6'(eo[i]) || state_o !== 3'(es[i])) begin n_bad++;
            $display("FAIL t1_seq[%0d] out=%0d st=%0d exp %0d/%0d", i, out_o, state_o, eo[i], es[i]); end
      end
      n_cmp++; if (active_o !== 1'b0 || table_line_o !== 32'd1 || table_repeat_o !== 32'd1) begin n_bad++;
         $display("FAIL t1_end act=%0d line=%0d trep=%0d exp 0/1/1", active_o, table_line_o, table_repeat_o); end
      enable_i = 1'b0;  step();
   endtask

   task automatic test_bit_trigger();
      PRESCALE = 32'd1;  REPEATS = 32'd1;  bit_i = '0;
      tbl[0] = 32'h0011_0003;  tbl[1] = 32'h5;  tbl[2] = 32'h1;
      tbl[3] = 32'h1;          tbl[4] = 32'h3;  tbl[5] = 32'h1;
      program_tbl(6);
      start_run();  step(5);
      n_cmp++; if (state_o !== 3'd3 || out_o !== 6'd0 || line_repeat_o !== 32'd1) begin n_bad++;
         $display("FAIL t2_wait st=%0d out=%0d lrep=%0d exp 3/0/1", state_o, out_o, line_repeat_o); end
      for (int r = 1; r <= 3; r++) begin
         bit_i = 3'b010;  step();  bit_i = '0;
         n_cmp++; if (state_o !== 3'd4 || out_o !== 6'd5 || line_repeat_o !== 32'(r)) begin n_bad++;
            $display("FAIL t2_ph[%0d] st=%0d out=%0d lrep=%0d exp 4/5/%0d", r, state_o, out_o, line_repeat_o, r); end
         step();
         if (r < 3) begin
            n_cmp++; if (state_o !== 3'd3 || line_repeat_o !== 32'(r + 1)) begin n_bad++;
               $display("FAIL t2_rep[%0d] st=%0d lrep=%0d exp 3/%0d", r, state_o, line_repeat_o, r + 1); end
            step();
            n_cmp++; if (state_o !== 3'd3) begin n_bad++; $display("FAIL t2_hold[%0d] st=%0d exp 3", r, state_o); end
         end
      end
      n_cmp++; if (state_o !== 3'd2 || table_line_o !== 32'd2 || line_repeat_o !== 32'd1) begin n_bad++;
         $display("FAIL t2_next st=%0d line=%0d lrep=%0d exp 2/2/1", state_o, table_line_o, line_repeat_o); end
      step(3);
      n_cmp++; if (state_o !== 3'd4 || out_o !== 6'd3) begin n_bad++;
         $display("FAIL t2_line2 st=%0d out=%0d exp 4/3", state_o, out_o); end
      step();
      n_cmp++; if (state_o !== 3'd1 || active_o !== 1'b0) begin n_bad++;
         $display("FAIL t2_end st=%0d act=%0d exp 1/0", state_o, active_o); end
      enable_i = 1'b0;  step();
   endtask

   task automatic test_prescale_repeats();
      int cnt = 0;
      int ph = 0;
      PRESCALE = 32'd4;  REPEATS = 32'd3;
      tbl[0] = 32'h1;  tbl[1] = 32'h1;  tbl[2] = 32'h2;
      tbl[3] = 32'h1;  tbl[4] = 32'h2;  tbl[5] = 32'h2;
      program_tbl(6);
      start_run();
      for (int i = 0; i < 200; i++) begin
         step();  cnt++;
         if (state_o === 3'd4 && table_line_o === 32'd1 && table_repeat_o === 32'd1) ph++;
         if (state_o === 3'd1) break;
      end
      n_cmp++; if (ph != 8) begin n_bad++; $display("FAIL t3_phase_len got=%0d exp 8", ph); end
      n_cmp++; if (cnt != 67) begin n_bad++; $display("FAIL t3_total got=%0d exp 67", cnt); end
      n_cmp++; if (table_repeat_o !== 32'd3 || table_line_o !== 32'd2 || out_o !== 6'd0) begin n_bad++;
         $display("FAIL t3_end trep=%0d line=%0d out=%0d exp 3/2/0", table_repeat_o, table_line_o, out_o); end
      enable_i = 1'b0;  step();
   endtask

   task automatic test_infinite_drop();
      bit ok = 1'b0;
      PRESCALE = 32'd1;  REPEATS = 32'd0;
      tbl[0] = 32'h1;  tbl[1] = 32'h3F;  tbl[2] = 32'h5;
      program_tbl(3);
      start_run();
      for (int i = 0; i < 100; i++) begin
         step();
         if (table_repeat_o === 32'd3 && state_o === 3'd4) begin ok = 1'b1; break; end
      end
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL t4_reach trep=%0d st=%0d exp 3/4", table_repeat_o, state_o); end
      step(2);
      n_cmp++; if (state_o !== 3'd4 || out_o !== 6'h3F) begin n_bad++;
         $display("FAIL t4_mid st=%0d out=%0d exp 4/63", state_o, out_o); end
      enable_i = 1'b0;  step();
      n_cmp++; if (state_o !== 3'd1 || out_o !== 6'd0 || active_o !== 1'b0) begin n_bad++;
         $display("FAIL t4_drop st=%0d out=%0d act=%0d exp 1/0/0", state_o, out_o, active_o); end
      n_cmp++; if (table_repeat_o !== 32'd3 || table_line_o !== 32'd1 || line_repeat_o !== 32'd1) begin n_bad++;
         $display("FAIL t4_hold trep=%0d line=%0d lrep=%0d exp 3/1/1", table_repeat_o, table_line_o, line_repeat_o); end
   endtask

   task automatic test_bad_length();
      TABLE_START = 1'b1;  step();  TABLE_START = 1'b0;
      commit(16'd4);
      n_cmp++; if (health_o !== 1'b1 || state_o !== 3'd0) begin n_bad++;
         $display("FAIL t5_len4 hl=%0d st=%0d exp 1/0", health_o, state_o); end
      start_run();  step(3);
      n_cmp++; if (state_o !== 3'd0 || active_o !== 1'b0) begin n_bad++;
         $display("FAIL t5_noen st=%0d act=%0d exp 0/0", state_o, active_o); end
      enable_i = 1'b0;
      TABLE_START = 1'b1;  step();  TABLE_START = 1'b0;
      for (int i = 0; i < 3 * DEPTH; i++) wr(32'h1);
      commit(16'(3 * DEPTH));
      n_cmp++; if (health_o !== 1'b0 || state_o !== 3'd1) begin n_bad++;
         $display("FAIL t5_full hl=%0d st=%0d exp 0/1", health_o, state_o); end
      wr(32'hDEAD_BEEF);
      n_cmp++; if (health_o !== 1'b1 || state_o !== 3'd1) begin n_bad++;
         $display("FAIL t5_ovf hl=%0d st=%0d exp 1/1", health_o, state_o); end
      commit(16'(3 * DEPTH + 3));
      n_cmp++; if (health_o !== 1'b1 || state_o !== 3'd0) begin n_bad++;
         $display("FAIL t5_toolong hl=%0d st=%0d exp 1/0", health_o, state_o); end
   endtask

   task automatic test_abort();
      bit ok;
      PRESCALE = 32'd1;  REPEATS = 32'd1;
      tbl[0] = 32'h1;  tbl[1] = 32'h0002_0001;  tbl[2] = 32'h0003_0002;
      program_tbl(3);
      start_run();  step();
      wait_st(3'd5, 20, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL t6_reach st=%0d exp 5", state_o); end
      TABLE_START = 1'b1;  step();  TABLE_START = 1'b0;
      n_cmp++; if (state_o !== 3'd0 || out_o !== 6'd0 || active_o !== 1'b0) begin n_bad++;
         $display("FAIL t6_abort st=%0d out=%0d act=%0d exp 0/0/0", state_o, out_o, active_o); end
      n_cmp++; if (table_line_o !== 32'd0 || line_repeat_o !== 32'd0 || table_repeat_o !== 32'd0) begin n_bad++;
         $display("FAIL t6_cnt line=%0d lrep=%0d trep=%0d exp 0", table_line_o, line_repeat_o, table_repeat_o); end
      enable_i = 1'b0;  step();
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      PRESCALE = 32'd1;  REPEATS = 32'd0;
      tbl[0] = 32'h1;  tbl[1] = 32'h15;  tbl[2] = 32'h5;
      program_tbl(3);
      start_run();  step();
      wait_st(3'd4, 20, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL t7_reach st=%0d exp 4", state_o); end
      commit(16'd3);
      n_cmp++; if (health_o !== 1'b1 || state_o !== 3'd4) begin n_bad++;
         $display("FAIL t7_len_active hl=%0d st=%0d exp 1/4", health_o, state_o); end
      reset_i = 1'b1;  step();
      n_cmp++; if ({out_o, active_o, health_o, state_o} !== '0) begin n_bad++;
         $display("FAIL t7_rst_outs out=%0d act=%0d hl=%0d st=%0d exp all 0", out_o, active_o, health_o, state_o); end
      n_cmp++; if ({table_line_o, line_repeat_o, table_repeat_o} !== '0) begin n_bad++;
         $display("FAIL t7_rst_cnts line=%0d lrep=%0d trep=%0d exp 0", table_line_o, line_repeat_o, table_repeat_o); end
      reset_i = 1'b0;  enable_i = 1'b0;  step();
   endtask

   initial begin
      test_reset();
      test_single_line();
      test_bit_trigger();
      test_prescale_repeats();
      test_infinite_drop();
      test_bad_length();
      test_abort();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
